// File: rtl/otter_lsu.sv
`default_nettype none
// otter_lsu: load/store unit for the OTTER data port; splits misaligned RAM accesses into aligned sub-accesses.
// Rev 1.0. Define OTTER_LSU_MISALIGN_TRAP_EN to reject misaligned requests instead of splitting them.
module otter_lsu #(
  parameter logic [31:0] MMIO_BASE = 32'h0001_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGN,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAP, STB, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;
  logic        phase_q, phase_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] w0_q, w0_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_mis;
  logic        req_err;
  logic [31:0] acc_addr;
  logic [63:0] merged;
  logic [31:0] mis_result;
  logic [1:0]  cnt_last;

  assign req_mis = ((REQ_SIZE == 2'd1) && (REQ_ADDR[1:0] == 2'd3)) ||
                   ((REQ_SIZE == 2'd2) && (REQ_ADDR[1:0] != 2'd0));

`ifdef OTTER_LSU_MISALIGN_TRAP_EN
  assign req_err = (REQ_SIZE == 2'd3) || req_mis;
`else
  logic [31:0] req_last;
  logic        req_io;
  // A misaligned access may not touch the IO range at all, including straddling into it.
  assign req_last = REQ_ADDR + ((REQ_SIZE == 2'd2) ? 32'd3 : 32'd1);
  assign req_io   = (REQ_ADDR >= MMIO_BASE) || (req_last >= MMIO_BASE);
  assign req_err  = (REQ_SIZE == 2'd3) || (req_mis && req_io);
`endif

  assign acc_addr = mis_q ? ({addr_q[31:2], 2'b00} + {29'd0, phase_q, 2'b00}) : addr_q;
  assign merged   = {MEM_DOUT2, w0_q} >> {addr_q[1:0], 3'b000};
  assign cnt_last = (size_q == 2'd2) ? 2'd3 : 2'd1;

  always_comb begin
    mis_result = merged[31:0];
    if (size_q == 2'd1) begin
      mis_result = {(sign_q ? 16'h0000 : {16{merged[15]}}), merged[15:0]};
    end
  end

  assign REQ_READY = (state_q == IDLE);
  assign RSP_VALID = (state_q == RESP);
  assign RSP_ERR   = (state_q == RESP) && err_q;
  assign RSP_RDATA = rdata_q;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    sign_d    = sign_q;
    mis_d     = mis_q;
    err_d     = err_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    w0_d      = w0_q;
    rdata_d   = rdata_q;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    MEM_ADDR2 = 32'd0;
    MEM_DIN2  = 32'd0;
    MEM_SIZE  = 2'd0;
    MEM_SIGN  = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          we_d    = REQ_WE;
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
          size_d  = REQ_SIZE;
          sign_d  = REQ_SIGN;
          mis_d   = req_mis;
          err_d   = req_err;
          phase_d = 1'b0;
          cnt_d   = 2'd0;
          if (req_err) begin
            rdata_d = 32'd0;
            state_d = RESP;
          end else if (REQ_WE && req_mis) begin
            state_d = STB;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        MEM_ADDR2 = acc_addr;
        MEM_SIZE  = mis_q ? 2'd2 : size_q;
        MEM_SIGN  = mis_q ? 1'b1 : sign_q;
        if (we_q) begin
          MEM_WE2  = 1'b1;
          MEM_DIN2 = wdata_q;
          rdata_d  = 32'd0;
          state_d  = RESP;
        end else begin
          MEM_RDEN2 = 1'b1;
          state_d   = CAP;
        end
      end
      CAP: begin
        // The memory sizes its read data from the live address/size, so they stay put here.
        MEM_ADDR2 = acc_addr;
        MEM_SIZE  = mis_q ? 2'd2 : size_q;
        MEM_SIGN  = mis_q ? 1'b1 : sign_q;
        if (mis_q && !phase_q) begin
          w0_d    = MEM_DOUT2;
          phase_d = 1'b1;
          state_d = ISSUE;
        end else begin
          rdata_d = mis_q ? mis_result : MEM_DOUT2;
          state_d = RESP;
        end
      end
      STB: begin
        MEM_WE2   = 1'b1;
        MEM_ADDR2 = addr_q + {30'd0, cnt_q};
        MEM_DIN2  = {24'd0, wdata_q[{cnt_q, 3'b000} +: 8]};
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == cnt_last) begin
          rdata_d = 32'd0;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      sign_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      phase_q <= 1'b0;
      cnt_q   <= 2'd0;
      w0_q    <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      w0_q    <= w0_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_otter_lsu.sv
`default_nettype none
// tb_otter_lsu: randomized bench for otter_lsu with a byte-array reference model and a synchronous memory model.
module tb_otter_lsu;

  localparam logic [31:0] MMIO = 32'h0001_0000;

  logic        CLK;
  logic        RST_N;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic [1:0]  REQ_SIZE;
  logic        REQ_SIGN;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        MEM_RDEN2;
  logic        MEM_WE2;
  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2;

  otter_lsu #(.MMIO_BASE(MMIO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_SIZE(REQ_SIZE), .REQ_SIGN(REQ_SIGN),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous 64 KiB memory: raw word registered on RDEN2, sized combinationally from the live controls.
  logic [7:0]  mem [0:65535];
  logic [31:0] raw_q;
  logic [15:0] wa;
  logic [31:0] sh;
  int          nb;
  assign wa = {MEM_ADDR2[15:2], 2'b00};
  assign nb = (MEM_SIZE == 2'd0) ? 1 : (MEM_SIZE == 2'd1) ? 2 : 4;

  always @(posedge CLK) begin
    if (MEM_WE2)
      for (int i = 0; i < 4; i++)
        if (i < nb) mem[MEM_ADDR2[15:0] + 16'(i)] <= MEM_DIN2[8*i +: 8];
    if (MEM_RDEN2) raw_q <= {mem[wa + 16'd3], mem[wa + 16'd2], mem[wa + 16'd1], mem[wa]};
  end

  always_comb begin
    sh = raw_q >> {MEM_ADDR2[1:0], 3'b000};
    case (MEM_SIZE)
      2'd0:    MEM_DOUT2 = MEM_SIGN ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'd1:    MEM_DOUT2 = MEM_SIGN ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: MEM_DOUT2 = sh;
    endcase
  end

  logic [7:0]  model_mem [0:65535];
  logic [31:0] wlog_addr [$];
  logic [31:0] wlog_din [$];
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: outcome of one request derived from the address/size rules over a flat byte array.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic sign,
                                output logic e_err, output int e_lat, output int e_rd,
                                output int e_wr, output logic [31:0] e_rdata);
    int n;
    logic mis;
    longint last;
    logic [31:0] v;
    n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mis  = ((size == 2'd1) && (addr[1:0] == 2'd3)) || ((size == 2'd2) && (addr[1:0] != 2'd0));
    last = longint'(addr) + longint'(n) - 1;
    e_err = (size == 2'd3) || (mis && ((addr >= MMIO) || (last >= longint'(MMIO))));
`ifdef OTTER_LSU_MISALIGN_TRAP_EN
    e_err = e_err || mis;
`endif
    e_rdata = 32'd0;
    e_rd = 0;
    e_wr = 0;
    if (e_err) begin
      e_lat = 1;
    end else if (we) begin
      e_lat = mis ? n + 1 : 2;
      e_wr  = mis ? n : 1;
      for (int i = 0; i < n; i++) model_mem[16'(addr + 32'(i))] = wdata[8*i +: 8];
    end else begin
      e_lat = mis ? 5 : 3;
      e_rd  = mis ? 2 : 1;
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(model_mem[16'(addr + 32'(i))]) << (8*i));
      if (!sign && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      e_rdata = v;
    end
  endfunction

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic sign, output logic [31:0] got);
    logic e_err;
    int e_lat, e_rd, e_wr, lat, rd, wr, both;
    logic [31:0] e_rdata;
    @(negedge CLK);
    check("ready_idle", {31'd0, REQ_READY}, 32'd1);
    check("rsp_idle_low", {31'd0, RSP_VALID}, 32'd0);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_WDATA = wdata; REQ_SIZE = size; REQ_SIGN = sign;
    model(we, addr, wdata, size, sign, e_err, e_lat, e_rd, e_wr, e_rdata);
    wlog_addr.delete();
    wlog_din.delete();
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0; REQ_WE = 1'($urandom); REQ_ADDR = $urandom; REQ_WDATA = $urandom;
    REQ_SIZE = 2'($urandom); REQ_SIGN = 1'($urandom);
    lat = 0; rd = 0; wr = 0; both = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      if (c == 1) check("ready_busy", {31'd0, REQ_READY}, 32'd0);
      rd += int'(MEM_RDEN2);
      wr += int'(MEM_WE2);
      both += int'(MEM_RDEN2 & MEM_WE2);
      if (MEM_WE2) begin
        wlog_addr.push_back(MEM_ADDR2);
        wlog_din.push_back(MEM_DIN2);
      end
      if (RSP_VALID) begin
        lat = c;
        break;
      end
    end
    check("latency", 32'(lat), 32'(e_lat));
    check("rsp_err", {31'd0, RSP_ERR}, {31'd0, e_err});
    check("rsp_rdata", RSP_RDATA, e_rdata);
    check("rden_pulses", 32'(rd), 32'(e_rd));
    check("we_pulses", 32'(wr), 32'(e_wr));
    check("rd_we_overlap", 32'(both), 32'd0);
    got = RSP_RDATA;
  endtask

  logic [31:0] g;
  logic [31:0] d;
  int wr_cnt;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'd0;
      model_mem[i] = 8'd0;
    end
    raw_q = 32'd0;
    RST_N = 1'b0; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = 32'd0;
    REQ_WDATA = 32'd0; REQ_SIZE = 2'd0; REQ_SIGN = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", {31'd0, REQ_READY}, 32'd1);
    check("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    check("rst_rsp_err", {31'd0, RSP_ERR}, 32'd0);
    check("rst_rden", {31'd0, MEM_RDEN2}, 32'd0);
    check("rst_we", {31'd0, MEM_WE2}, 32'd0);
    check("rst_rdata", RSP_RDATA, 32'd0);
    check("rst_addr2", MEM_ADDR2, 32'd0);
    check("rst_din2", MEM_DIN2, 32'd0);
    RST_N = 1'b1;

    do_req(1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0, g);
    do_req(1'b0, 32'h100, 32'd0, 2'd2, 1'b0, g);
    check("tp_word", g, 32'hDEAD_BEEF);
    do_req(1'b1, 32'h100, 32'h80FF_0000, 2'd2, 1'b0, g);
    do_req(1'b0, 32'h103, 32'd0, 2'd0, 1'b0, g);
    check("tp_sbyte", g, 32'hFFFF_FF80);
    do_req(1'b0, 32'h103, 32'd0, 2'd0, 1'b1, g);
    check("tp_ubyte", g, 32'h0000_0080);

    do_req(1'b1, 32'h202, 32'h1122_3344, 2'd2, 1'b0, g);
`ifndef OTTER_LSU_MISALIGN_TRAP_EN
    d = 32'h1122_3344;
    check("tp_mst_count", 32'(wlog_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wlog_addr.size()) begin
        check("tp_mst_addr", wlog_addr[i], 32'h202 + 32'(i));
        check("tp_mst_din", {24'd0, wlog_din[i][7:0]}, {24'd0, d[8*i +: 8]});
      end
    end
`endif
    do_req(1'b0, 32'h202, 32'd0, 2'd2, 1'b0, g);
`ifndef OTTER_LSU_MISALIGN_TRAP_EN
    check("tp_mld_word", g, 32'h1122_3344);
`endif
    do_req(1'b1, 32'h0, 32'hAB00_0000, 2'd2, 1'b0, g);
    do_req(1'b1, 32'h4, 32'h0000_00CD, 2'd2, 1'b0, g);
    do_req(1'b0, 32'h3, 32'd0, 2'd1, 1'b0, g);
`ifndef OTTER_LSU_MISALIGN_TRAP_EN
    check("tp_mld_half", g, 32'hFFFF_CDAB);
`endif
    do_req(1'b0, 32'h40, 32'd0, 2'd3, 1'b0, g);
    do_req(1'b0, 32'hFFFE, 32'd0, 2'd2, 1'b0, g);
    check("tp_straddle_rdata", g, 32'd0);
`ifdef OTTER_LSU_MISALIGN_TRAP_EN
    do_req(1'b0, 32'h1, 32'd0, 2'd2, 1'b0, g);
`else
    // Reset during a split store after its second byte write.
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 32'h202; REQ_WDATA = 32'hA1B2_C3D4;
    REQ_SIZE = 2'd2; REQ_SIGN = 1'b0;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    wr_cnt = 0;
    for (int c = 0; c < 8 && wr_cnt < 2; c++) begin
      @(negedge CLK);
      if (MEM_WE2) wr_cnt++;
    end
    check("rst_mid_writes", 32'(wr_cnt), 32'd2);
    RST_N = 1'b0;
    model_mem[16'h202] = 8'hD4;
    model_mem[16'h203] = 8'hC3;
    @(negedge CLK);
    RST_N = 1'b1;
    check("rstm_ready", {31'd0, REQ_READY}, 32'd1);
    check("rstm_we", {31'd0, MEM_WE2}, 32'd0);
    check("rstm_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    check("rstm_rdata", RSP_RDATA, 32'd0);
    check("rstm_addr2", MEM_ADDR2, 32'd0);
    check("rstm_din2", MEM_DIN2, 32'd0);
    wr_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (MEM_WE2) wr_cnt++;
    end
    check("rstm_no_more_we", 32'(wr_cnt), 32'd0);
    do_req(1'b0, 32'h202, 32'd0, 2'd2, 1'b0, g);
    check("rstm_partial", g, 32'h1122_C3D4);
`endif

    for (int t = 0; t < 400; t++) begin
      logic [31:0] a;
      logic [1:0]  s;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      a = 32'($urandom_range(0, 63));
      else if (sel < 9) a = 32'hFFF8 + 32'($urandom_range(0, 7));
      else              a = MMIO + 32'($urandom_range(0, 15));
      s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_req(1'($urandom), a, $urandom, s, 1'($urandom), g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/otter_lsu.md
Name: otter_lsu

Overview:
Load/store unit sitting directly upstream of the OTTER data port (ADDR2 side) of the 64k synchronous memory.
- Accepts one CPU load/store request per valid/ready handshake.
- Drives the memory's RDEN2/WE2/ADDR2/DIN2/SIZE/SIGN and captures the synchronous read data.
- Splits misaligned RAM accesses into legal aligned sub-accesses, merges the results and returns a single response pulse.

Parameters:
- MMIO_BASE, 32'h0001_0000, first address of the external IO range; addresses >= MMIO_BASE are never split.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  synchronous, active-low reset
- REQ_VALID  in  1  request valid
- REQ_READY  out  1  LSU idle, can accept a request
- REQ_WE  in  1  1 = store, 0 = load
- REQ_ADDR  in  32  byte address
- REQ_WDATA  in  32  store data, right-aligned
- REQ_SIZE  in  2  0 byte, 1 half, 2 word, 3 illegal
- REQ_SIGN  in  1  1 unsigned, 0 signed
- RSP_VALID  out  1  one-cycle completion pulse
- RSP_RDATA  out  32  load result, sized and extended (0 for stores)
- RSP_ERR  out  1  request rejected, no memory access
- MEM_RDEN2  out  1  memory data read enable
- MEM_WE2  out  1  memory write enable
- MEM_ADDR2  out  32  memory data address
- MEM_DIN2  out  32  memory write data
- MEM_SIZE  out  2  memory access size
- MEM_SIGN  out  1  memory extension mode
- MEM_DOUT2  in  32  memory read data, valid the cycle after RDEN2

Behaviour:
Reset (RST_N low at a clock edge):
- State returns to IDLE. REQ_READY=1. RSP_VALID, RSP_ERR, MEM_RDEN2 and MEM_WE2 are 0. RSP_RDATA, MEM_ADDR2 and MEM_DIN2 are 0.
- Reset applied mid-operation abandons the operation immediately, with no further strobes. A split store may be left partially written; this is accepted behaviour.

Handshake:
- REQ_READY=1 only in IDLE. The request is latched on the edge where REQ_VALID & REQ_READY.
- REQ_* inputs are don't-care after acceptance.

Classification at acceptance (off = ADDR[1:0]):
- ERR: REQ_SIZE=3; or misaligned with ADDR >= MMIO_BASE; or a misaligned access whose bytes straddle MMIO_BASE-1/MMIO_BASE.
- Misaligned: half with off=3; word with off!=0.
- Otherwise the access is aligned.

States: IDLE, ISSUE, CAP, STB, RESP.
- ERR path: IDLE -> RESP. In RESP: RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0.
- Aligned load:
  - ISSUE: RDEN2=1 with ADDR2/SIZE/SIGN equal to the request.
  - CAP: RDEN2=0, same ADDR2/SIZE/SIGN held (the memory sizes its read data combinationally from them); MEM_DOUT2 is registered.
  - RESP.
  - RSP_VALID asserts in the 3rd cycle after acceptance.
- Aligned store: ISSUE with WE2=1 and request address/size/data -> RESP. RSP_VALID asserts in the 2nd cycle after acceptance.
- Misaligned load:
  - w0 = ADDR & ~3, w1 = w0+4.
  - Sequence: ISSUE(w0) -> CAP -> ISSUE(w1) -> CAP -> RESP, using MEM_SIZE=2 and MEM_SIGN=1 for both reads.
  - Result = ({w1data,w0data} >> 8*off), truncated to 16/32 bits, then sign- or zero-extended per REQ_SIGN.
  - RSP_VALID asserts in the 5th cycle after acceptance.
- Misaligned store:
  - STB issues n byte writes (n=2 half, 4 word), one per cycle, in ascending order.
  - Each write: MEM_SIZE=0, ADDR2 = ADDR+i, DIN2[7:0] = WDATA[8i+7:8i].
  - Then RESP. RSP_VALID asserts in cycle n+1 after acceptance.
- Address arithmetic is modulo 2^32.
- RESP lasts exactly one cycle, then the block returns to IDLE. A new request can be accepted in the cycle after RESP.
- RSP_RDATA holds its last value until the next RESP. RSP_ERR=0 on all non-error responses.
- MEM_RDEN2 and MEM_WE2 are never both 1 in the same cycle.

Optional Feature:
Macro OTTER_LSU_MISALIGN_TRAP_EN.
- Defined: misaligned requests are never split. They complete as ERR (RSP_VALID in the cycle after acceptance, RSP_ERR=1) with no memory access.
- Undefined: misaligned requests are split as described above; RSP_ERR is raised only for the ERR classification.

Test Plan:
- Aligned word: store 0xDEADBEEF to 0x100, then load word from 0x100 -> RSP_RDATA=0xDEADBEEF; RSP_VALID exactly 3 cycles after load acceptance; one RDEN2 pulse.
- Signed byte: load byte at 0x103 with SIGN=0 after storing 0x80FF_0000 at 0x100 -> 0xFFFFFF80. Same load with SIGN=1 -> 0x00000080.
- Misaligned word, feature off: store 0x11223344 to 0x202 -> four WE2 pulses at 0x202..0x205 carrying 0x44, 0x33, 0x22, 0x11. Word load from 0x202 -> 0x11223344, latency 5.
- Misaligned half across words: load half at 0x3 with SIGN=0, where word 0x0=0xAB000000 and word 0x4=0x000000CD -> 0xFFFFCDAB.
- Errors: size=3 request, and a word load at 0xFFFE (straddles MMIO_BASE) -> RSP_ERR=1, RSP_RDATA=0, no RDEN2/WE2 pulse.
- Reset mid misaligned store after the 2nd byte write -> no further WE2; outputs at reset values and REQ_READY=1 on the cycle following the reset edge.
  - With OTTER_LSU_MISALIGN_TRAP_EN defined, a word load at 0x1 -> RSP_ERR=1 in the cycle after acceptance.
